// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS-style ALU: word width, bench clock period
// and the ALU-control op-code encoding.
package alu_pkg;

    localparam int WORD  = 32;
    localparam int CYCLE = 10;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational op decode and datapath: (A, B, op) -> result.
// Unlisted op codes produce zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_control,
    output logic [WIDTH-1:0] result
);

    logic less_than;

    assign less_than = ($signed(A) < $signed(B));

    always_comb begin
        // NOTE: default first so every path assigns result and no latch is inferred.
        result = '0;
        case (ALU_control)
            ALU_AND: result = A & B;
            ALU_OR:  result = A | B;
            ALU_ADD: result = A + B;
            ALU_SUB: result = A - B;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, less_than};
            ALU_NOR: result = ~(A | B);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// MIPS-style ALU with a registered result (one-cycle latency) and a zero flag
// decoded from the result register.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_control,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero
);

    logic [WIDTH-1:0] core_result;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .A           (A),
        .B           (B),
        .ALU_control (ALU_control),
        .result      (core_result)
    );

    // Reset is synchronous and wins over whatever op is presented at the same edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for registered state avoids simulation races.
        if (reset) ALUresult <= '0;
        else       ALUresult <= core_result;
    end

    assign zero = ~|ALUresult;

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for alu: vector table plus hand-written
// sequences for reset, mid-stream reset and between-edge input changes.
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_control;
    logic [31:0] ALUresult;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs[16];

    alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .A           (A),
        .B           (B),
        .ALU_control (ALU_control),
        .ALUresult   (ALUresult),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #(CYCLE / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        A           = a;
        B           = b;
        ALU_control = op;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"add_5_1",      32'd5,          32'd1,          4'b0010, 32'd6,          1'b0};
        vecs[1]  = '{"sub_5_1",      32'd5,          32'd1,          4'b0110, 32'd4,          1'b0};
        vecs[2]  = '{"and_5_1",      32'd5,          32'd1,          4'b0000, 32'd1,          1'b0};
        vecs[3]  = '{"or_5_1",       32'd5,          32'd1,          4'b0001, 32'd5,          1'b0};
        vecs[4]  = '{"nor_5_1",      32'd5,          32'd1,          4'b1100, 32'hFFFF_FFFA,  1'b0};
        vecs[5]  = '{"slt_5_1",      32'd5,          32'd1,          4'b0111, 32'd0,          1'b1};
        vecs[6]  = '{"sub_1111_1",   32'h1111,       32'd1,          4'b0110, 32'h1110,       1'b0};
        vecs[7]  = '{"sub_1_1",      32'd1,          32'd1,          4'b0110, 32'd0,          1'b1};
        vecs[8]  = '{"slt_m1_1",     32'hFFFF_FFFF,  32'd1,          4'b0111, 32'd1,          1'b0};
        vecs[9]  = '{"add_wrap",     32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          1'b1};
        vecs[10] = '{"op_1111",      32'd5,          32'd1,          4'b1111, 32'd0,          1'b1};
        vecs[11] = '{"op_0011",      32'hAAAA_5555,  32'h1234_5678,  4'b0011, 32'd0,          1'b1};
        vecs[12] = '{"slt_1_m1",     32'd1,          32'hFFFF_FFFF,  4'b0111, 32'd0,          1'b1};
        vecs[13] = '{"slt_min_max",  32'h8000_0000,  32'h7FFF_FFFF,  4'b0111, 32'd1,          1'b0};
        vecs[14] = '{"sub_0_1",      32'd0,          32'd1,          4'b0110, 32'hFFFF_FFFF,  1'b0};
        vecs[15] = '{"add_min_min",  32'h8000_0000,  32'h8000_0000,  4'b0010, 32'd0,          1'b1};

        // Reset held for two cycles with a non-zero op present.
        reset       = 1'b1;
        A           = 32'd5;
        B           = 32'd1;
        ALU_control = 4'b0010;
        after_edge();
        after_edge();
        check("reset_result", ALUresult, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd1);

        @(negedge clk);
        reset = 1'b0;

        // Back-to-back vectors, one new op per cycle.
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].op);
            after_edge();
            check({vecs[i].name, "_res"}, ALUresult, vecs[i].exp_res);
            check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_zero});
        end

        // Inputs changing between edges must not disturb the registered result.
        apply(32'd5, 32'd1, 4'b0010);
        after_edge();
        check("hold_before", ALUresult, 32'd6);
        A           = 32'd100;
        ALU_control = 4'b0110;
        #2;
        check("hold_mid_cycle", ALUresult, 32'd6);
        after_edge();
        check("hold_next_edge", ALUresult, 32'd99);

        // Mid-stream reset with ADD active, then release and resume.
        apply(32'd5, 32'd1, 4'b0010);
        after_edge();
        check("mid_add_before", ALUresult, 32'd6);
        @(negedge clk);
        reset = 1'b1;
        after_edge();
        check("mid_reset_result", ALUresult, 32'd0);
        check("mid_reset_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        after_edge();
        check("mid_resume_add", ALUresult, 32'd6);
        check("mid_resume_zero", {31'd0, zero}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
